// File: rtl/chart_note_sequencer.sv
// Chart note sequencer: walks the song chart ROM in order and offers each entry to the
// note pool LEAD frames ahead of its timestamp, over a valid/ready handshake.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | after reset, waiting for start
// S_FETCH | rom_addr stable, covering the one-cycle ROM latency
// S_LOAD  | capture rom_data into the entry registers
// S_HOLD  | wait for the frame count to reach entry timestamp minus LEAD
// S_EMIT  | note offered to the pool, held until accepted
// S_DONE  | chart exhausted or song stopped; start rewinds
module chart_note_sequencer #(
    parameter int          ADDR_W = 8,
    parameter int          LANE_W = 2,
    parameter logic [15:0] LEAD   = 16'd60,
    parameter logic [15:0] END_TS = 16'hFFFF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop_sign,
    input  logic [15:0]          un_time,
    output logic [ADDR_W-1:0]    rom_addr,
    input  logic [15+LANE_W:0]   rom_data,
    output logic                 note_valid,
    input  logic                 note_ready,
    output logic [LANE_W-1:0]    note_lane,
    output logic [15:0]          note_ts,
    output logic [ADDR_W:0]      note_count,
    output logic                 chart_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_HOLD,
        S_EMIT,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    state_t              state, state_n;
    logic [ADDR_W-1:0]   rom_addr_n;
    logic [15:0]         entry_ts, entry_ts_n;
    logic [LANE_W-1:0]   entry_lane, entry_lane_n;
    logic                note_valid_n;
    logic [LANE_W-1:0]   note_lane_n;
    logic [15:0]         note_ts_n;
    logic [ADDR_W:0]     note_count_n;
    logic                chart_done_n;
    logic                go_done;
    logic [16:0]         lead_sum;
    logic                due;

    // 17-bit compare so a timestamp near the top of the frame range never wraps past LEAD
    assign lead_sum = {1'b0, un_time} + {1'b0, LEAD};
    assign due      = (lead_sum >= {1'b0, entry_ts});

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            rom_addr   <= '0;
            entry_ts   <= '0;
            entry_lane <= '0;
            note_valid <= 1'b0;
            note_lane  <= '0;
            note_ts    <= '0;
            note_count <= '0;
            chart_done <= 1'b0;
        end else begin
            state      <= state_n;
            rom_addr   <= rom_addr_n;
            entry_ts   <= entry_ts_n;
            entry_lane <= entry_lane_n;
            note_valid <= note_valid_n;
            note_lane  <= note_lane_n;
            note_ts    <= note_ts_n;
            note_count <= note_count_n;
            chart_done <= chart_done_n;
        end
    end

    always_comb begin
        state_n      = state;
        rom_addr_n   = rom_addr;
        entry_ts_n   = entry_ts;
        entry_lane_n = entry_lane;
        note_valid_n = note_valid;
        note_lane_n  = note_lane;
        note_ts_n    = note_ts;
        note_count_n = note_count;
        chart_done_n = chart_done;
        go_done      = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    rom_addr_n   = '0;
                    note_count_n = '0;
                    state_n      = S_FETCH;
                end
            end
            S_FETCH: begin
                if (stop_sign) go_done = 1'b1;
                else           state_n = S_LOAD;
            end
            S_LOAD: begin
                if (stop_sign) begin
                    go_done = 1'b1;
                end else begin
                    entry_ts_n   = rom_data[LANE_W +: 16];
                    entry_lane_n = rom_data[LANE_W-1:0];
                    state_n      = S_HOLD;
                end
            end
            S_HOLD: begin
                if (stop_sign || entry_ts == END_TS) begin
                    go_done = 1'b1;
                end else if (due) begin
                    note_valid_n = 1'b1;
                    note_lane_n  = entry_lane;
                    note_ts_n    = entry_ts;
                    state_n      = S_EMIT;
                end
            end
            S_EMIT: begin
                // stop outranks ready: the offered note is dropped uncounted
                if (stop_sign) begin
                    go_done = 1'b1;
                end else if (note_ready) begin
                    note_valid_n = 1'b0;
                    note_count_n = note_count + (ADDR_W+1)'(1);
                    if (rom_addr == ADDR_MAX) begin
                        go_done = 1'b1;
                    end else begin
                        rom_addr_n = rom_addr + ADDR_W'(1);
                        state_n    = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                if (start) begin
                    chart_done_n = 1'b0;
                    rom_addr_n   = '0;
                    note_count_n = '0;
                    state_n      = S_FETCH;
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (go_done) begin
            state_n      = S_DONE;
            note_valid_n = 1'b0;
            chart_done_n = 1'b1;
        end
    end

endmodule

// File: tb/tb_chart_note_sequencer.sv
// Bench for chart_note_sequencer: directed chart scenarios plus randomized charts, timing and
// handshakes, checked every cycle against a frame/entry-level reference model and a note scoreboard.
module tb_chart_note_sequencer;

    localparam int          ADDR_W = 2;
    localparam int          LANE_W = 2;
    localparam int          DEPTH  = 4;
    localparam logic [15:0] LEAD   = 16'd60;
    localparam logic [15:0] END_TS = 16'hFFFF;

    logic                 clk;
    logic                 reset;
    logic                 start;
    logic                 stop_sign;
    logic [15:0]          un_time;
    logic [ADDR_W-1:0]    rom_addr;
    logic [15+LANE_W:0]   rom_data;
    logic                 note_valid;
    logic                 note_ready;
    logic [LANE_W-1:0]    note_lane;
    logic [15:0]          note_ts;
    logic [ADDR_W:0]      note_count;
    logic                 chart_done;

    chart_note_sequencer #(
        .ADDR_W(ADDR_W), .LANE_W(LANE_W), .LEAD(LEAD), .END_TS(END_TS)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .stop_sign(stop_sign), .un_time(un_time),
        .rom_addr(rom_addr), .rom_data(rom_data), .note_valid(note_valid),
        .note_ready(note_ready), .note_lane(note_lane), .note_ts(note_ts),
        .note_count(note_count), .chart_done(chart_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0]       chart_ts   [DEPTH];
    logic [LANE_W-1:0] chart_lane [DEPTH];

    always @(posedge clk) rom_data <= {chart_ts[rom_addr], chart_lane[rom_addr]};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [15:0]       ts;
        logic [LANE_W-1:0] lane;
    } note_t;
    note_t exp_q[$];

    // Reference model: chart position, notes accepted, and the pipeline delay between
    // rewinding/advancing and the entry being ready to be judged against the frame count.
    bit                armed    = 0;
    bit                m_active = 0;
    bit                m_done   = 0;
    bit                m_offer  = 0;
    int                m_idx    = 0;
    int                m_count  = 0;
    int                m_wait   = 0;
    logic [15:0]       m_ts     = '0;
    logic [LANE_W-1:0] m_lane   = '0;

    always @(negedge clk) begin
        note_t e;
        if (armed) begin
            check("note_valid", note_valid, m_offer);
            if (m_offer) begin
                check("note_lane", note_lane, m_lane);
                check("note_ts", note_ts, m_ts);
            end
            check("note_count", note_count, m_count);
            check("chart_done", chart_done, m_done);
            check("rom_addr", rom_addr, m_idx);
            if (m_offer && note_ready && !stop_sign && !reset) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_lane", note_lane, e.lane);
                    check("sb_ts", note_ts, e.ts);
                end
            end
        end

        if (reset) begin
            armed = 1; m_active = 0; m_done = 0; m_offer = 0;
            m_idx = 0; m_count = 0; m_wait = 0; m_ts = '0; m_lane = '0;
            exp_q.delete();
        end else if (!m_active) begin
            if (start) begin
                m_active = 1; m_done = 0; m_idx = 0; m_count = 0; m_wait = 2;
                exp_q.delete();
                for (int i = 0; i < DEPTH; i++) begin
                    if (chart_ts[i] == END_TS) break;
                    exp_q.push_back('{ts: chart_ts[i], lane: chart_lane[i]});
                end
            end
        end else if (stop_sign) begin
            m_active = 0; m_done = 1; m_offer = 0;
        end else if (m_offer) begin
            if (note_ready) begin
                m_offer = 0;
                m_count++;
                if (m_idx == DEPTH - 1) begin
                    m_active = 0; m_done = 1;
                end else begin
                    m_idx++;
                    m_wait = 2;
                end
            end
        end else if (m_wait > 0) begin
            m_wait--;
        end else if (chart_ts[m_idx] == END_TS) begin
            m_active = 0; m_done = 1;
        end else if (int'(un_time) + int'(LEAD) >= int'(chart_ts[m_idx])) begin
            m_offer = 1; m_ts = chart_ts[m_idx]; m_lane = chart_lane[m_idx];
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (note_valid) break;
            tick();
        end
        check(name, note_valid, 1);
    endtask

    task automatic wait_done(input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (chart_done) break;
            tick();
        end
        check(name, chart_done, 1);
    endtask

    task automatic set_chart(input logic [15:0] t0, t1, t2, t3, input logic [7:0] lanes);
        chart_ts[0] = t0; chart_ts[1] = t1; chart_ts[2] = t2; chart_ts[3] = t3;
        for (int i = 0; i < DEPTH; i++) chart_lane[i] = lanes[2*i +: 2];
    endtask

    task automatic run_random(input int budget, input int rdy_pct, input int stop_pm);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if ($urandom_range(0, 199) == 0 && un_time > 0)
                un_time = un_time - 16'($urandom_range(0, int'(un_time)));
            else
                un_time = un_time + 16'($urandom_range(0, 2));
            note_ready = ($urandom_range(0, 99) < rdy_pct);
            stop_sign  = ($urandom_range(0, 999) < stop_pm);
            start      = ($urandom_range(0, 39) == 0);
            tick();
            if (chart_done) break;
        end
        start = 1'b0; stop_sign = 1'b0; note_ready = 1'b0;
        check("rand_done", chart_done, 1);
        tick();
    endtask

    initial begin
        int          k1, k2;
        logic [15:0] un_at;
        reset = 1'b1; start = 1'b0; stop_sign = 1'b0; un_time = '0; note_ready = 1'b0;
        set_chart(END_TS, END_TS, END_TS, END_TS, 8'h00);
        tick(); tick();
        check("rst_valid", note_valid, 0);
        check("rst_done", chart_done, 0);
        check("rst_count", note_count, 0);
        check("rst_addr", rom_addr, 0);
        reset = 1'b0;
        tick();

        // two notes due at frame 100, issued at frame 40 and back-to-back
        set_chart(16'd100, 16'd100, END_TS, END_TS, 8'b00_00_10_01);
        un_time = '0; note_ready = 1'b1;
        k1 = -1; k2 = -1; un_at = '0;
        pulse_start();
        for (int k = 0; k < 800; k++) begin
            if (note_valid && note_lane == 2'd1 && k1 < 0) begin k1 = k; un_at = un_time; end
            if (note_valid && note_lane == 2'd2 && k2 < 0) k2 = k;
            if (chart_done) break;
            un_time = 16'(k >> 3);
            tick();
        end
        check("t1_offer_frame", un_at, 40);
        check("t1_gap", k2 - k1, 4);
        check("t1_done", chart_done, 1);
        check("t1_count", note_count, 2);

        // ready held low: offer stays stable
        set_chart(16'd10, END_TS, END_TS, END_TS, 8'b00_00_00_11);
        un_time = '0; note_ready = 1'b0;
        pulse_start();
        wait_valid(20, "t2_valid_wait");
        repeat (20) tick();
        check("t2_valid", note_valid, 1);
        check("t2_lane", note_lane, 3);
        check("t2_ts", note_ts, 10);
        note_ready = 1'b1;
        tick();
        note_ready = 1'b0;
        wait_done(20, "t2_done");
        check("t2_count", note_count, 1);

        // stop outranks ready
        set_chart(16'd5, 16'd20, END_TS, END_TS, 8'b00_00_10_01);
        pulse_start();
        wait_valid(20, "t3_valid_wait");
        note_ready = 1'b1; stop_sign = 1'b1;
        tick();
        note_ready = 1'b0; stop_sign = 1'b0;
        check("t3_valid", note_valid, 0);
        check("t3_done", chart_done, 1);
        check("t3_count", note_count, 0);
        tick();

        // full chart with no end marker
        set_chart(16'd0, 16'd10, 16'd20, 16'd30, 8'b11_10_01_00);
        un_time = 16'd100; note_ready = 1'b1;
        pulse_start();
        wait_done(60, "t4_done");
        check("t4_count", note_count, 4);
        check("t4_addr", rom_addr, 3);

        // restart from DONE; a start pulse in HOLD is ignored
        note_ready = 1'b0;
        pulse_start();
        check("t5_addr", rom_addr, 0);
        check("t5_count", note_count, 0);
        check("t5_done", chart_done, 0);
        tick(); tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t5_valid", note_valid, 1);
        check("t5_lane", note_lane, 0);
        check("t5_ts", note_ts, 0);
        note_ready = 1'b1;
        wait_done(60, "t5_finish");
        note_ready = 1'b0;

        // reset while a note is on offer
        set_chart(16'd0, END_TS, END_TS, END_TS, 8'b00_00_00_01);
        pulse_start();
        wait_valid(20, "t6_valid_wait");
        reset = 1'b1;
        tick();
        check("t6_valid", note_valid, 0);
        check("t6_done", chart_done, 0);
        check("t6_count", note_count, 0);
        check("t6_addr", rom_addr, 0);
        check("t6_lane", note_lane, 0);
        check("t6_ts", note_ts, 0);
        reset = 1'b0;
        tick();

        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                chart_ts[i]   = ($urandom_range(0, 4) == 0) ? END_TS : 16'($urandom_range(0, 250));
                chart_lane[i] = LANE_W'($urandom_range(0, 3));
            end
            un_time = 16'($urandom_range(0, 50));
            run_random(1500, $urandom_range(20, 100), (r % 2 == 0) ? 0 : 3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        repeat (90000) @(posedge clk);
        n_bad++;
        $display("FAIL watchdog: run still active after 90000 cycles, required to finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
